// File: rtl/cam_sensor_emulator.sv
// Camera-sensor transmitter: raster frames with programmable active size and
// blanking, filled with selectable test patterns, one pixel per clk.
module cam_sensor_emulator #(
  parameter int DATA_W   = 12,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_BLANK  = 16,
  parameter int V_FRONT  = 8,
  parameter int V_BACK   = 8,
  parameter int V_BLANK  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [1:0]        pattern_sel,
  input  logic              cam_reset_n,
  output logic [DATA_W-1:0] cam_data,
  output logic              cam_lvalid,
  output logic              cam_fvalid,
  output logic              frame_done,
  output logic [15:0]       frame_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_FRONT, S_LINE, S_HBLANK, S_BACK, S_VBLANK
  } state_t;

  state_t            state_q, state_d;
  logic [11:0]       col_q, col_d, row_q, row_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [1:0]        pat_q, pat_d;
  logic [15:0]       frame_count_q, frame_count_d;
  logic [DATA_W-1:0] cam_data_q, cam_data_d;
  logic              lvalid_q, lvalid_d;
  logic              fvalid_q, fvalid_d;
  logic              done_q, done_d;
  logic [11:0]       pix;

  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    row_d         = row_q;
    cnt_d         = cnt_q;
    pat_d         = pat_q;
    frame_count_d = frame_count_q;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_FRONT;
          cnt_d   = 16'(V_FRONT - 1);
          pat_d   = pattern_sel;
        end
      end
      S_FRONT: begin
        if (cnt_q == 16'd0) begin
          state_d = S_LINE;
          col_d   = '0;
          row_d   = '0;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_LINE: begin
        if (col_q == 12'(H_ACTIVE - 1)) begin
          if (row_q < 12'(V_ACTIVE - 1)) begin
            state_d = S_HBLANK;
            cnt_d   = 16'(H_BLANK - 1);
          end else begin
            state_d = S_BACK;
            cnt_d   = 16'(V_BACK - 1);
          end
        end else begin
          col_d = col_q + 12'd1;
        end
      end
      S_HBLANK: begin
        if (cnt_q == 16'd0) begin
          state_d = S_LINE;
          col_d   = '0;
          row_d   = row_q + 12'd1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_BACK: begin
        if (cnt_q == 16'd0) begin
          state_d       = S_VBLANK;
          cnt_d         = 16'(V_BLANK - 1);
          frame_count_d = frame_count_q + 16'd1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_VBLANK: begin
        if (cnt_q == 16'd0) begin
          if (enable) begin
            state_d = S_FRONT;
            cnt_d   = 16'(V_FRONT - 1);
            pat_d   = pattern_sel;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are derived from the next state so the registered copies line up with it.
    fvalid_d = state_d inside {S_FRONT, S_LINE, S_HBLANK, S_BACK};
    lvalid_d = (state_d == S_LINE);
    done_d   = (state_q == S_BACK) && (state_d == S_VBLANK);
    case (pat_d)
      2'd0:    pix = col_d;
      2'd1:    pix = row_d;
      2'd2:    pix = (col_d[3] ^ row_d[3]) ? 12'hFFF : 12'h000;
      default: pix = col_d + row_d + frame_count_q[11:0];
    endcase
    cam_data_d = lvalid_d ? DATA_W'(pix) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset || !cam_reset_n) begin
      state_q    <= S_IDLE;
      col_q      <= '0;
      row_q      <= '0;
      cnt_q      <= '0;
      pat_q      <= '0;
      cam_data_q <= '0;
      lvalid_q   <= 1'b0;
      fvalid_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      cnt_q      <= cnt_d;
      pat_q      <= pat_d;
      cam_data_q <= cam_data_d;
      lvalid_q   <= lvalid_d;
      fvalid_q   <= fvalid_d;
      done_q     <= done_d;
    end
  end

  // The sensor reset from camera_control leaves the completed-frame count alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_count_q <= '0;
    end else if (cam_reset_n) begin
      frame_count_q <= frame_count_d;
    end
  end

  assign cam_data    = cam_data_q;
  assign cam_lvalid  = lvalid_q;
  assign cam_fvalid  = fvalid_q;
  assign frame_done  = done_q;
  assign frame_count = frame_count_q;

endmodule
